// File: rtl/gambit_decode_queue.sv
// rtl/gambit_decode_queue.sv - multi-lane instruction decode feeding an in-order DEPTH-entry decode queue
// Define GAMBIT_DECQ_BYPASS_EN to present decoded input lanes in the same cycle when the queue is empty.
module gambit_decode_queue #(
  parameter int LANES = 2,
  parameter int DEPTH = 8,
  parameter int CW    = 52
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic [LANES-1:0]         in_valid_i,
  input  logic [LANES*52-1:0]      in_instr_i,
  input  logic [LANES-1:0]         in_pt_i,
  output logic                     in_ready_o,
  output logic [LANES-1:0]         out_valid_o,
  output logic [LANES*(CW+26)-1:0] out_bus_o,
  input  logic [LANES-1:0]         out_take_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int BW = CW + 26;
  localparam int PW = $clog2(DEPTH);
  localparam int NW = PW + 1;
  localparam logic [NW-1:0] FREE_MAX = NW'(DEPTH - LANES);

  localparam logic [6:0] OP_ADD_RI8  = 7'h01;
  localparam logic [6:0] OP_ADD_RI22 = 7'h02;
  localparam logic [6:0] OP_ADD_RI35 = 7'h03;
  localparam logic [6:0] OP_CMP_RI22 = 7'h04;
  localparam logic [6:0] OP_FADD_RI8 = 7'h10;
  localparam logic [6:0] OP_FMUL_RI8 = 7'h11;
  localparam logic [6:0] OP_LDB_D8   = 7'h20;
  localparam logic [6:0] OP_LDB_D22  = 7'h21;
  localparam logic [6:0] OP_LDT_D22  = 7'h22;
  localparam logic [6:0] OP_LDT_NDX  = 7'h23;
  localparam logic [6:0] OP_STB_D8   = 7'h28;
  localparam logic [6:0] OP_STB_D22  = 7'h29;
  localparam logic [6:0] OP_STT_D22  = 7'h2A;
  localparam logic [6:0] OP_STCR     = 7'h2B;
  localparam logic [6:0] OP_JAL      = 7'h30;
  localparam logic [6:0] OP_BR       = 7'h31;
  localparam logic [6:0] OP_BRK      = 7'h32;
  localparam logic [6:0] OP_RET      = 7'h33;
  localparam logic [6:0] OP_MEMSB    = 7'h38;
  localparam logic [6:0] OP_MEMDB    = 7'h39;
  localparam logic [6:0] OP_SYNC     = 7'h3A;
  localparam logic [6:0] OP_FSYNC    = 7'h3B;

  localparam logic [3:0] MEMSZ_BYT   = 4'd0;
  localparam logic [3:0] MEMSZ_TETRA = 4'd2;

  localparam int F_CMP = 0,  F_ALU = 1,  F_ALU0 = 2,  F_FPU = 3,  F_FPU0 = 4,  F_FC = 5;
  localparam int F_LOAD = 6, F_STORE = 7, F_STCR = 8, F_MEM = 9, F_MEMNDX = 10, F_JAL = 11;
  localparam int F_BR = 12,  F_BRK = 13, F_RET = 14, F_MEMSB = 15, F_MEMDB = 16, F_SYNC = 17;
  localparam int F_FSYNC = 18, F_RFW = 19, F_CANEX = 20, F_PT = 21;

  // x is the instruction's immediate field, i[51:17]
  function automatic logic [BW-1:0] decode(input logic [6:0] op, input logic [34:0] x,
                                           input logic pt);
    logic        c8, c22, fp, byt;
    logic [21:0] f;
    logic [51:0] c;
    logic [CW-1:0] cx;
    c8 = 1'b0; c22 = 1'b0; fp = 1'b0; byt = 1'b0; f = '0;
    case (op)
      OP_ADD_RI8:  begin c8 = 1'b1;  f[F_ALU] = 1'b1; f[F_RFW] = 1'b1; end
      OP_ADD_RI22: begin c22 = 1'b1; f[F_ALU] = 1'b1; f[F_RFW] = 1'b1; end
      OP_ADD_RI35: begin f[F_ALU] = 1'b1; f[F_RFW] = 1'b1; end
      OP_CMP_RI22: begin
        c22 = 1'b1; f[F_CMP] = 1'b1; f[F_ALU] = 1'b1; f[F_ALU0] = 1'b1; f[F_RFW] = 1'b1;
      end
      OP_FADD_RI8: begin
        c8 = 1'b1; fp = 1'b1; f[F_FPU] = 1'b1; f[F_RFW] = 1'b1; f[F_CANEX] = 1'b1;
      end
      OP_FMUL_RI8: begin
        c8 = 1'b1; fp = 1'b1; f[F_FPU] = 1'b1; f[F_FPU0] = 1'b1; f[F_RFW] = 1'b1;
        f[F_CANEX] = 1'b1;
      end
      OP_LDB_D8, OP_LDB_D22, OP_LDT_D22, OP_LDT_NDX: begin
        c8  = (op == OP_LDB_D8);
        c22 = (op == OP_LDB_D22) || (op == OP_LDT_D22);
        byt = (op == OP_LDB_D8) || (op == OP_LDB_D22);
        f[F_MEMNDX] = (op == OP_LDT_NDX);
        f[F_LOAD] = 1'b1; f[F_MEM] = 1'b1; f[F_RFW] = 1'b1; f[F_CANEX] = 1'b1;
      end
      OP_STB_D8, OP_STB_D22, OP_STT_D22, OP_STCR: begin
        c8  = (op == OP_STB_D8);
        c22 = (op == OP_STB_D22) || (op == OP_STT_D22);
        byt = (op == OP_STB_D8) || (op == OP_STB_D22);
        f[F_STCR] = (op == OP_STCR);
        f[F_STORE] = 1'b1; f[F_MEM] = 1'b1; f[F_CANEX] = 1'b1;
      end
      OP_JAL:   begin f[F_FC] = 1'b1; f[F_JAL] = 1'b1; f[F_RFW] = 1'b1; end
      OP_BR:    begin c22 = 1'b1; f[F_FC] = 1'b1; f[F_BR] = 1'b1; end
      OP_BRK:   begin f[F_FC] = 1'b1; f[F_BRK] = 1'b1; f[F_CANEX] = 1'b1; end
      OP_RET:   begin f[F_FC] = 1'b1; f[F_RET] = 1'b1; end
      OP_MEMSB: f[F_MEMSB] = 1'b1;
      OP_MEMDB: f[F_MEMDB] = 1'b1;
      OP_SYNC:  f[F_SYNC] = 1'b1;
      OP_FSYNC: f[F_FSYNC] = 1'b1;
      default:  ;
    endcase
    f[F_PT] = pt;
    // ri8.one: build a double with biased exponent 1015+e and 4-bit mantissa
    if (fp && x[8])
      c = {1'b0, 11'd1015 + {7'd0, x[7:4]}, x[3:0], 36'd0};
    else if (c8)
      c = {{44{x[7]}}, x[7:0]};
    else if (c22)
      c = {{30{x[21]}}, x[21:0]};
    else
      c = {{17{x[34]}}, x};
    cx = fp ? CW'(c) : CW'($signed(c));
    return {f, (byt ? MEMSZ_BYT : MEMSZ_TETRA), cx};
  endfunction

  function automatic logic [NW-1:0] lead_ones(input logic [LANES-1:0] v);
    logic [NW-1:0] n;
    logic          run;
    n = '0;
    run = 1'b1;
    for (int k = 0; k < LANES; k++) begin
      run = run & v[k];
      if (run) n = n + NW'(1);
    end
    return n;
  endfunction

  logic [PW-1:0]  r_head;
  logic [PW-1:0]  r_tail;
  logic [NW-1:0]  r_count;
  logic [BW-1:0]  r_mem [DEPTH];

  logic [BW-1:0]  w_dec [LANES];
  logic [LANES-1:0] w_unused;
  logic           w_bypass;
  logic [NW-1:0]  w_push_n;
  logic [NW-1:0]  w_pop_n;
  logic [NW-1:0]  w_skip_n;
  logic [NW-1:0]  w_wr_n;
  logic [NW-1:0]  w_deq_n;

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      w_dec[k]    = decode(in_instr_i[k*52 +: 7], in_instr_i[k*52+17 +: 35], in_pt_i[k]);
      w_unused[k] = ^in_instr_i[k*52+7 +: 10];
    end
  end

`ifdef GAMBIT_DECQ_BYPASS_EN
  assign w_bypass = (r_count == '0) && !flush_i;
`else
  assign w_bypass = 1'b0;
`endif

  assign in_ready_o = (r_count <= FREE_MAX);
  assign count_o    = r_count;
  assign w_push_n   = in_ready_o ? lead_ones(in_valid_i) : '0;

  always_comb begin
    logic [PW-1:0] idx;
    idx         = '0;
    out_valid_o = '0;
    out_bus_o   = '0;
    for (int k = 0; k < LANES; k++) begin
      idx = r_head + PW'(k);
      if (w_bypass) begin
        if (NW'(k) < w_push_n) begin
          out_valid_o[k]          = 1'b1;
          out_bus_o[k*BW +: BW]   = w_dec[k];
        end
      end else if (r_count > NW'(k)) begin
        out_valid_o[k]            = 1'b1;
        out_bus_o[k*BW +: BW]     = r_mem[idx];
      end
    end
  end

  // In bypass the popped lanes come straight from the input and never touch storage
  assign w_pop_n  = lead_ones(out_take_i & out_valid_o);
  assign w_skip_n = w_bypass ? w_pop_n : '0;
  assign w_wr_n   = w_push_n - w_skip_n;
  assign w_deq_n  = w_pop_n - w_skip_n;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PW'(w_deq_n);
      r_tail  <= r_tail + PW'(w_wr_n);
      r_count <= r_count + w_wr_n - w_deq_n;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!flush_i) begin
      for (int k = 0; k < LANES; k++) begin
        if ((NW'(k) >= w_skip_n) && (NW'(k) < w_push_n))
          r_mem[r_tail + PW'(NW'(k) - w_skip_n)] <= w_dec[k];
      end
    end
  end

endmodule

// File: tb/tb_gambit_decode_queue.sv
// tb/tb_gambit_decode_queue.sv - directed bench with a queue-level reference model for gambit_decode_queue
// Build with GAMBIT_DECQ_BYPASS_EN defined to exercise the same-cycle bypass expectations.
module tb_gambit_decode_queue;

  localparam int LANES = 2;
  localparam int DEPTH = 8;
  localparam int CW    = 52;
  localparam int BW    = CW + 26;
  localparam int NW    = $clog2(DEPTH) + 1;
`ifdef GAMBIT_DECQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam logic [6:0] OP_ADD_RI8 = 7'h01, OP_ADD_RI22 = 7'h02, OP_ADD_RI35 = 7'h03;
  localparam logic [6:0] OP_CMP_RI22 = 7'h04, OP_FADD_RI8 = 7'h10, OP_FMUL_RI8 = 7'h11;
  localparam logic [6:0] OP_LDB_D8 = 7'h20, OP_LDB_D22 = 7'h21, OP_LDT_D22 = 7'h22;
  localparam logic [6:0] OP_LDT_NDX = 7'h23, OP_STB_D8 = 7'h28, OP_STB_D22 = 7'h29;
  localparam logic [6:0] OP_STT_D22 = 7'h2A, OP_STCR = 7'h2B, OP_JAL = 7'h30, OP_BR = 7'h31;
  localparam logic [6:0] OP_BRK = 7'h32, OP_RET = 7'h33, OP_MEMSB = 7'h38, OP_MEMDB = 7'h39;
  localparam logic [6:0] OP_SYNC = 7'h3A, OP_FSYNC = 7'h3B;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic                flush_i;
  logic [LANES-1:0]    in_valid_i;
  logic [LANES*52-1:0] in_instr_i;
  logic [LANES-1:0]    in_pt_i;
  logic                in_ready_o;
  logic [LANES-1:0]    out_valid_o;
  logic [LANES*BW-1:0] out_bus_o;
  logic [LANES-1:0]    out_take_i;
  logic [NW-1:0]       count_o;

  int tests = 0;
  int fails = 0;

  logic [BW-1:0]       mq [$];
  logic [LANES-1:0]    exp_v;
  logic [LANES*BW-1:0] exp_bus;
  logic [51:0]         t2 [8];
  logic [6:0]          ops [22] = '{OP_ADD_RI8, OP_ADD_RI22, OP_ADD_RI35, OP_CMP_RI22,
                                    OP_FADD_RI8, OP_FMUL_RI8, OP_LDB_D8, OP_LDB_D22,
                                    OP_LDT_D22, OP_LDT_NDX, OP_STB_D8, OP_STB_D22,
                                    OP_STT_D22, OP_STCR, OP_JAL, OP_BR, OP_BRK, OP_RET,
                                    OP_MEMSB, OP_MEMDB, OP_SYNC, OP_FSYNC};
  logic [4:0]          pat [16] = '{5'b11_00_0, 5'b01_01_0, 5'b11_01_0, 5'b10_00_0,
                                    5'b11_11_0, 5'b01_00_0, 5'b00_11_0, 5'b11_10_0,
                                    5'b11_00_1, 5'b01_00_0, 5'b11_01_0, 5'b11_11_0,
                                    5'b00_01_0, 5'b11_00_0, 5'b11_00_0, 5'b00_11_0};

  gambit_decode_queue #(.LANES(LANES), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_instr_i  (in_instr_i),
    .in_pt_i     (in_pt_i),
    .in_ready_o  (in_ready_o),
    .out_valid_o (out_valid_o),
    .out_bus_o   (out_bus_o),
    .out_take_i  (out_take_i),
    .count_o     (count_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [51:0] mk(input logic [6:0] op, input logic [34:0] c);
    return {c, 10'd0, op};
  endfunction

  function automatic int lo(input logic [LANES-1:0] v);
    int n;
    n = 0;
    for (int k = 0; k < LANES; k++) begin
      if (!v[k]) break;
      n++;
    end
    return n;
  endfunction

  // Reference decode built from opcode class membership
  function automatic logic [BW-1:0] mdec(input logic [51:0] i, input logic pt);
    logic [6:0]  op;
    logic [51:0] c;
    logic [21:0] f;
    logic [3:0]  sz;
    op = i[6:0];
    if ((op inside {OP_FADD_RI8, OP_FMUL_RI8}) && i[25])
      c = {1'b0, 11'd1015 + 11'(i[24:21]), i[20:17], 36'd0};
    else if (op inside {OP_ADD_RI8, OP_FADD_RI8, OP_FMUL_RI8, OP_LDB_D8, OP_STB_D8})
      c = {{44{i[24]}}, i[24:17]};
    else if (op inside {OP_ADD_RI22, OP_CMP_RI22, OP_LDB_D22, OP_LDT_D22, OP_STB_D22,
                        OP_STT_D22, OP_BR})
      c = {{30{i[38]}}, i[38:17]};
    else
      c = {{17{i[51]}}, i[51:17]};
    sz = (op inside {OP_LDB_D8, OP_LDB_D22, OP_STB_D8, OP_STB_D22}) ? 4'd0 : 4'd2;
    f = '0;
    f[0]  = (op == OP_CMP_RI22);
    f[1]  = op inside {OP_ADD_RI8, OP_ADD_RI22, OP_ADD_RI35, OP_CMP_RI22};
    f[2]  = (op == OP_CMP_RI22);
    f[3]  = op inside {OP_FADD_RI8, OP_FMUL_RI8};
    f[4]  = (op == OP_FMUL_RI8);
    f[6]  = op inside {OP_LDB_D8, OP_LDB_D22, OP_LDT_D22, OP_LDT_NDX};
    f[7]  = op inside {OP_STB_D8, OP_STB_D22, OP_STT_D22, OP_STCR};
    f[8]  = (op == OP_STCR);
    f[9]  = f[6] | f[7];
    f[10] = (op == OP_LDT_NDX);
    f[11] = (op == OP_JAL);
    f[12] = (op == OP_BR);
    f[13] = (op == OP_BRK);
    f[14] = (op == OP_RET);
    f[5]  = |f[14:11];
    f[15] = (op == OP_MEMSB);
    f[16] = (op == OP_MEMDB);
    f[17] = (op == OP_SYNC);
    f[18] = (op == OP_FSYNC);
    f[19] = f[1] | f[3] | f[6] | f[11];
    f[20] = f[3] | f[9] | f[13];
    f[21] = pt;
    return {f, sz, c};
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_view();
    int nv;
    exp_v   = '0;
    exp_bus = '0;
    if (rst_ni) begin
      if (BYP && mq.size() == 0 && !flush_i) begin
        nv = lo(in_valid_i);
        for (int k = 0; k < nv; k++) begin
          exp_v[k] = 1'b1;
          exp_bus[k*BW +: BW] = mdec(in_instr_i[k*52 +: 52], in_pt_i[k]);
        end
      end else begin
        for (int k = 0; k < LANES; k++) begin
          if (k < mq.size()) begin
            exp_v[k] = 1'b1;
            exp_bus[k*BW +: BW] = mq[k];
          end
        end
      end
    end
  endtask

  task automatic settle();
    @(negedge clk_i);
    model_view();
    chk("count", count_o, mq.size());
    chk("in_ready", in_ready_o, (DEPTH - mq.size()) >= LANES);
    chk("out_valid", out_valid_o, exp_v);
    chk("out_bus", out_bus_o, exp_bus);
  endtask

  task automatic adv();
    int            pn, qn;
    bit            byp, fl;
    logic [BW-1:0] d [LANES];
    model_view();
    pn  = ((DEPTH - mq.size()) >= LANES) ? lo(in_valid_i) : 0;
    qn  = lo(out_take_i & exp_v);
    byp = BYP && mq.size() == 0 && !flush_i;
    fl  = flush_i;
    for (int k = 0; k < LANES; k++) d[k] = mdec(in_instr_i[k*52 +: 52], in_pt_i[k]);
    @(posedge clk_i);
    if (!rst_ni || fl) begin
      mq.delete();
    end else if (byp) begin
      for (int k = qn; k < pn; k++) mq.push_back(d[k]);
    end else begin
      repeat (qn) void'(mq.pop_front());
      for (int k = 0; k < pn; k++) mq.push_back(d[k]);
    end
    #1;
  endtask

  task automatic cyc();
    settle();
    adv();
  endtask

  task automatic idle();
    in_valid_i = '0; in_instr_i = '0; in_pt_i = '0; out_take_i = '0; flush_i = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0;
    idle();
    settle();
    chk("rst_count", count_o, 0);
    chk("rst_valid", out_valid_o, 0);
    chk("rst_bus", out_bus_o, 0);
    adv();
    rst_ni = 1'b1;
    settle();
    chk("rst_ready", in_ready_o, 1);
    adv();

    // single ADD_RI22 with all-ones constant
    in_valid_i = 2'b01;
    in_instr_i = {52'd0, mk(OP_ADD_RI22, 35'h3FFFFF)};
    cyc();
    idle();
    settle();
    chk("t1_valid", out_valid_o, 2'b01);
    chk("t1_count", count_o, 1);
    chk("t1_const", out_bus_o[CW-1:0], 52'hFFFFFFFFFFFFF);
    chk("t1_memsz", out_bus_o[CW+3:CW], 4'd2);
    chk("t1_alu", out_bus_o[CW+5], 1'b1);
    chk("t1_rfw", out_bus_o[CW+23], 1'b1);
    chk("t1_cmp", out_bus_o[CW+4], 1'b0);
    adv();
    out_take_i = 2'b01;
    cyc();
    idle();

    // fill to DEPTH, then a dropped push
    t2[0] = mk(OP_LDB_D8, 35'h80);        t2[1] = mk(OP_ADD_RI8, 35'h05);
    t2[2] = mk(OP_FADD_RI8, 35'h13A);     t2[3] = mk(OP_CMP_RI22, 35'h12345);
    t2[4] = mk(OP_JAL, 35'h400000000);    t2[5] = mk(OP_STCR, 35'h7);
    t2[6] = mk(OP_BR, 35'h3FFFF0);        t2[7] = mk(OP_LDT_NDX, 35'h1);
    for (int c = 0; c < 4; c++) begin
      in_valid_i = 2'b11;
      in_instr_i = {t2[2*c+1], t2[2*c]};
      in_pt_i    = 2'(c);
      cyc();
    end
    idle();
    settle();
    chk("t2_count", count_o, 8);
    chk("t2_ready", in_ready_o, 0);
    chk("t2_head_const", out_bus_o[CW-1:0], 52'hFFFFFFFFFFF80);
    chk("t2_head_memsz", out_bus_o[CW+3:CW], 4'd0);
    chk("t2_head_load", out_bus_o[CW+10], 1'b1);
    adv();
    in_valid_i = 2'b11;
    in_instr_i = {mk(OP_FSYNC, 35'd0), mk(OP_SYNC, 35'd0)};
    cyc();
    idle();
    settle();
    chk("t2_drop_count", count_o, 8);
    chk("t2_drop_head", out_bus_o[CW-1:0], 52'hFFFFFFFFFFF80);
    adv();

    // full queue with simultaneous take/valid, then steady push+pop across the wrap
    in_valid_i = 2'b11;
    in_instr_i = {mk(OP_FSYNC, 35'd0), mk(OP_SYNC, 35'd0)};
    out_take_i = 2'b11;
    cyc();
    idle();
    settle();
    chk("t3_count", count_o, 6);
    chk("t3_head_const", out_bus_o[CW-1:0], 52'h3FAA000000000);
    chk("t3_head_fpu", out_bus_o[CW+7], 1'b1);
    adv();
    for (int j = 0; j < 6; j++) begin
      in_valid_i = 2'b11;
      out_take_i = 2'b11;
      in_instr_i = {mk(ops[(2*j+1) % 22], 35'(j*7919 + 3)), mk(ops[(2*j) % 22], 35'(j*104729 + 1))};
      in_pt_i    = 2'(j);
      cyc();
    end
    idle();
    settle();
    chk("t3_wrap_count", count_o, 6);
    adv();

    // non-leading valid/take lanes do nothing
    in_valid_i = 2'b10;
    in_instr_i = {mk(OP_RET, 35'd9), mk(OP_BRK, 35'd0)};
    out_take_i = 2'b10;
    cyc();
    idle();
    settle();
    chk("t4_count", count_o, 6);
    adv();

    // byte memory ops, then flush with a take in the same cycle
    flush_i = 1'b1;
    cyc();
    idle();
    in_valid_i = 2'b11;
    in_instr_i = {mk(OP_LDB_D22, 35'h200000), mk(OP_STB_D8, 35'h7F)};
    cyc();
    idle();
    flush_i    = 1'b1;
    out_take_i = 2'b01;
    settle();
    chk("t5_lane0_store", out_bus_o[CW+11], 1'b1);
    chk("t5_lane0_memsz", out_bus_o[CW+3:CW], 4'd0);
    chk("t5_lane1_const", out_bus_o[BW +: CW], 52'hFFFFFFFE00000);
    chk("t5_lane1_load", out_bus_o[BW+CW+10], 1'b1);
    adv();
    idle();
    settle();
    chk("t5_count", count_o, 0);
    chk("t5_valid", out_valid_o, 2'b00);
    adv();

    // push 2 into an empty queue while taking lane 0
    in_valid_i = 2'b11;
    in_instr_i = {mk(OP_MEMSB, 35'd0), mk(OP_ADD_RI35, 35'h700000001)};
    out_take_i = 2'b01;
    settle();
`ifdef GAMBIT_DECQ_BYPASS_EN
    chk("t6_byp_valid", out_valid_o, 2'b11);
    chk("t6_byp_const", out_bus_o[CW-1:0], 52'hFFFFF00000001);
`else
    chk("t6_reg_valid", out_valid_o, 2'b00);
    chk("t6_reg_count", count_o, 0);
`endif
    adv();
    idle();
    settle();
`ifdef GAMBIT_DECQ_BYPASS_EN
    chk("t6_byp_count", count_o, 1);
    chk("t6_byp_head", out_bus_o[CW+19], 1'b1);
`else
    chk("t6_reg_count2", count_o, 2);
    chk("t6_reg_head", out_bus_o[CW-1:0], 52'hFFFFF00000001);
`endif
    adv();
    out_take_i = 2'b11;
    cyc();
    cyc();
    idle();

    // mixed traffic from a pattern table {valid, take, flush}
    for (int r = 0; r < 32; r++) begin
      in_valid_i = pat[r % 16][4:3];
      out_take_i = pat[r % 16][2:1];
      flush_i    = pat[r % 16][0];
      in_pt_i    = 2'(r);
      in_instr_i = {mk(ops[(3*r+1) % 22], 35'(r*37 + 1001)), mk(ops[(3*r) % 22], 35'(r*911 + 5))};
      cyc();
    end
    idle();

    // async reset in the middle of a push cycle
    in_valid_i = 2'b11;
    in_instr_i = {mk(OP_JAL, 35'd4), mk(OP_ADD_RI8, 35'd1)};
    settle();
    #1;
    rst_ni = 1'b0;
    idle();
    #1;
    chk("arst_count", count_o, 0);
    chk("arst_valid", out_valid_o, 0);
    chk("arst_bus", out_bus_o, 0);
    mq.delete();
    adv();
    rst_ni = 1'b1;
    settle();
    chk("arst_ready", in_ready_o, 1);
    adv();
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
